// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_if
// Description : Requester and SDRAM-controller command/response bundle
//               shared by the SDRAM arbiter. The slave modport is the
//               arbiter's view. The master modport is the environment's
//               view (requesters plus controller).
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Requester side
    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*26-1:0] req_addr;
    logic [NUM_REQ*16-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           rsp_data;
    logic [NUM_REQ-1:0]    rsp_val;

    // Controller side
    logic                  mem_read;
    logic                  mem_write;
    logic [25:0]           mem_addr;
    logic [15:0]           mem_data_write;
    logic                  mem_cmd_ready;
    logic [15:0]           mem_data_read;
    logic                  mem_data_read_val;

    // Status
    logic                  err_orphan;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        input  mem_cmd_ready, mem_data_read, mem_data_read_val,
        output req_ready, rsp_data, rsp_val,
        output mem_read, mem_write, mem_addr, mem_data_write,
        output err_orphan
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        output mem_cmd_ready, mem_data_read, mem_data_read_val,
        input  req_ready, rsp_data, rsp_val,
        input  mem_read, mem_write, mem_addr, mem_data_write,
        input  err_orphan
    );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares one SDRAM controller command port among NUM_REQ
//               requesters. Arbitration is work-conserving round-robin, and
//               commands pass straight through with zero latency. Read bursts
//               are steered back to their issuer through a tag FIFO.
//               Optional macro SDRAM_ARB_PRIO0_EN gives requester 0 strict
//               priority. The other requesters round-robin among themselves.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BURST_WORDS = 8,
    parameter int TAG_DEPTH   = 4
) (
    input  wire             clk,
    input  wire             reset_n,
    sdram_arbiter_if.slave  bus
);

    localparam int c_ptr_w  = $clog2(NUM_REQ);
    localparam int c_tag_w  = $clog2(TAG_DEPTH);
    localparam int c_cnt_w  = c_tag_w + 1;
    localparam int c_beat_w = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int c_aw     = 26;
    localparam int c_dw     = 16;

    // Registered state
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_tag_w-1:0]  r_wr_ptr;
    logic [c_tag_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_beat_w-1:0] r_beat_cnt;
    logic                r_err_orphan;
    logic [c_ptr_w-1:0]  r_tag_mem [TAG_DEPTH];

    // Combinational signals
    logic                w_full;
    logic                w_empty;
    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [c_ptr_w-1:0]  w_winner;
    logic [c_ptr_w-1:0]  w_scan;
    logic                w_issue;
    logic                w_is_read;
    logic                w_push;
    logic                w_pop;
    logic                w_beat_ok;
    logic                w_rr_upd;
    logic [c_ptr_w-1:0]  w_sel;
    logic [c_ptr_w-1:0]  w_head;
    logic [NUM_REQ-1:0]  w_ready;
    logic [NUM_REQ-1:0]  w_rsp_val;
    logic [c_aw-1:0]     w_addr;
    logic [c_dw-1:0]     w_wdata;

    // The registered count gates eligibility, so a pop in this cycle does not unmask reads yet
    assign w_full  = (r_count == c_cnt_w'(TAG_DEPTH));
    assign w_empty = (r_count == '0);

    // Read-and-write from one requester counts as a read, so a full FIFO must mask it entirely
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_read[i]) begin
                w_elig[i] = ~w_full;
            end else begin
                w_elig[i] = bus.req_write[i];
            end
        end
    end

`ifdef SDRAM_ARB_PRIO0_EN
    // Requester 0 wins outright. The others are scanned after rr_ptr within 1..NUM_REQ-1
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        if (w_elig[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                w_scan = c_ptr_w'(1 + ((int'(r_rr_ptr) - 1 + k) % (NUM_REQ - 1)));
                if (!w_found && w_elig[w_scan]) begin
                    w_found  = 1'b1;
                    w_winner = w_scan;
                end
            end
        end
    end

    assign w_rr_upd = w_issue && (w_winner != '0);
`else
    // Scan eligible requesters starting one past the last grant; the first hit wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = c_ptr_w'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    assign w_rr_upd = w_issue;
`endif

    assign w_issue   = bus.mem_cmd_ready && w_found;
    assign w_is_read = bus.req_read[w_winner];
    assign w_push    = w_issue && w_is_read;
    assign w_head    = r_tag_mem[r_rd_ptr];
    assign w_beat_ok = bus.mem_data_read_val && !w_empty;
    assign w_pop     = w_beat_ok && (r_beat_cnt == c_beat_w'(BURST_WORDS - 1));

    // Command mux: drive from the winner on issue, otherwise from requester 0
    always_comb begin
        w_sel   = w_issue ? w_winner : '0;
        w_addr  = bus.req_addr[c_aw*int'(w_sel) +: c_aw];
        w_wdata = bus.req_wdata[c_dw*int'(w_sel) +: c_dw];
        w_ready = '0;
        if (w_issue) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    // Read beats are flagged only to the requester at the head of the tag FIFO
    always_comb begin
        w_rsp_val = '0;
        if (w_beat_ok) begin
            w_rsp_val[w_head] = 1'b1;
        end
    end

    // Gate the combinational outputs so that reset silences them at once
    assign bus.req_ready      = reset_n ? w_ready : '0;
    assign bus.mem_read       = reset_n & w_issue & w_is_read;
    assign bus.mem_write      = reset_n & w_issue & ~w_is_read;
    assign bus.mem_addr       = reset_n ? w_addr : '0;
    assign bus.mem_data_write = reset_n ? w_wdata : '0;
    assign bus.rsp_data       = reset_n ? bus.mem_data_read : '0;
    assign bus.rsp_val        = reset_n ? w_rsp_val : '0;
    assign bus.err_orphan     = r_err_orphan;

    // Round-robin pointer remembers the most recent eligible grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= c_ptr_w'(NUM_REQ - 1);
        end else if (w_rr_upd) begin
            r_rr_ptr <= w_winner;
        end
    end

    // Tag storage holds the issuing requester index of each outstanding read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

    // Tag FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat counter marks the end of each burst; orphan beats latch a sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_pop) begin
                r_beat_cnt <= '0;
            end else if (w_beat_ok) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (bus.mem_data_read_val && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench for sdram_arbiter. It uses a
//               scoreboard of expected grants and read beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] val;
        logic [15:0]  data;
    } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [N-1:0] q_ready [$];
    rsp_t         q_rsp   [$];

    sdram_arbiter_if #(.NUM_REQ(N)) bus ();

    sdram_arbiter #(
        .NUM_REQ     (N),
        .BURST_WORDS (8),
        .TAG_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req_read  = '0;
        bus.req_write = '0;
    endtask

    task automatic set_req(input int i, input bit rd, input logic [25:0] a, input logic [15:0] d);
        bus.req_read[i]           = rd;
        bus.req_write[i]          = ~rd;
        bus.req_addr[26*i +: 26]  = a;
        bus.req_wdata[16*i +: 16] = d;
    endtask

    task automatic expect_grant(input logic [N-1:0] m);
        q_ready.push_back(m);
    endtask

    // dst < 0 marks an orphan beat that must not raise any rsp_val
    task automatic beat(input logic [15:0] d, input int dst);
        rsp_t r;
        bus.mem_data_read     = d;
        bus.mem_data_read_val = 1'b1;
        r.val  = (dst < 0) ? '0 : N'(1 << dst);
        r.data = d;
        q_rsp.push_back(r);
    endtask

    task automatic sample(input string tag);
        logic [N-1:0] er;
        rsp_t         r;
        #1;
        if (q_ready.size() != 0) begin
            er = q_ready.pop_front();
            check({tag, "/req_ready"}, 32'(bus.req_ready), 32'(er));
        end
        if (q_rsp.size() != 0) begin
            r = q_rsp.pop_front();
            check({tag, "/rsp_val"}, 32'(bus.rsp_val), 32'(r.val));
            if (r.val != '0) begin
                check({tag, "/rsp_data"}, 32'(bus.rsp_data), 32'(r.data));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        bus.mem_data_read_val = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "/mem_read"},  32'(bus.mem_read), 32'h0);
        check({tag, "/mem_write"}, 32'(bus.mem_write), 32'h0);
        check({tag, "/mem_addr"},  32'(bus.mem_addr), 32'h0);
        check({tag, "/mem_wdata"}, 32'(bus.mem_data_write), 32'h0);
        check({tag, "/rsp_val"},   32'(bus.rsp_val), 32'h0);
        check({tag, "/rsp_data"},  32'(bus.rsp_data), 32'h0);
        check({tag, "/err_orphan"}, 32'(bus.err_orphan), 32'h0);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        adv();
        reset_n = 1'b1;
    endtask

    initial begin
        int idx;
        bus.req_read          = '0;
        bus.req_write         = '1;
        bus.req_addr          = {N{26'h3FFFFFF}};
        bus.req_wdata         = {N{16'hFFFF}};
        bus.mem_cmd_ready     = 1'b1;
        bus.mem_data_read     = 16'h5555;
        bus.mem_data_read_val = 1'b1;

        // Reset: everything quiet even with live inputs
        #2;
        check_all_zero("reset");
        clear_reqs();
        bus.mem_data_read_val = 1'b0;
        adv();
        reset_n = 1'b1;
        adv();

        // Single read from requester 1 followed by its 8-beat burst
        set_req(1, 1'b1, 26'h0001234, 16'h0);
        expect_grant(4'b0010);
        sample("rd1");
        check("rd1/mem_read",  32'(bus.mem_read), 32'h1);
        check("rd1/mem_write", 32'(bus.mem_write), 32'h0);
        check("rd1/mem_addr",  32'(bus.mem_addr), 32'h0001234);
        adv();
        clear_reqs();
        for (int k = 0; k < 8; k++) begin
            beat(16'hA000 + 16'(k), 1);
            expect_grant('0);
            sample("rd1_beat");
            adv();
        end

        // All four writing continuously right after reset
        reset_pulse();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 26'h100 + 26'(i), 16'h1000 + 16'(i));
        end
        for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_PRIO0_EN
            idx = 0;
`else
            idx = k % N;
`endif
            expect_grant(N'(1 << idx));
            sample("wr_rr");
            check("wr_rr/mem_write", 32'(bus.mem_write), 32'h1);
            check("wr_rr/mem_wdata", 32'(bus.mem_data_write), 32'h1000 + 32'(idx));
            check("wr_rr/mem_addr",  32'(bus.mem_addr), 32'h100 + 32'(idx));
            adv();
        end
        clear_reqs();

        // Controller stalls for 5 cycles, then accepts the pending write
        set_req(2, 1'b0, 26'h0ABCDEF, 16'h2222);
        bus.mem_cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            expect_grant('0);
            sample("stall");
            check("stall/mem_write", 32'(bus.mem_write), 32'h0);
            adv();
        end
        bus.mem_cmd_ready = 1'b1;
        expect_grant(4'b0100);
        sample("stall_go");
        check("stall_go/mem_write", 32'(bus.mem_write), 32'h1);
        adv();
        clear_reqs();

        // Fill the tag FIFO; a full FIFO masks reads but lets writes through
        set_req(0, 1'b1, 26'h0000040, 16'h0);
        for (int k = 0; k < 4; k++) begin
            expect_grant(4'b0001);
            sample("fill");
            check("fill/mem_read", 32'(bus.mem_read), 32'h1);
            adv();
        end
        set_req(3, 1'b0, 26'h0000333, 16'hBEEF);
        expect_grant(4'b1000);
        sample("full_wr");
        check("full_wr/mem_write", 32'(bus.mem_write), 32'h1);
        check("full_wr/mem_read",  32'(bus.mem_read), 32'h0);
        check("full_wr/mem_wdata", 32'(bus.mem_data_write), 32'hBEEF);
        adv();
        bus.req_write[3] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat(16'hB000 + 16'(k), 0);
            expect_grant('0);
            sample("full_beat");
            adv();
        end
        expect_grant(4'b0001);
        sample("unmask");
        check("unmask/mem_read", 32'(bus.mem_read), 32'h1);
        adv();
        clear_reqs();
        for (int k = 0; k < 32; k++) begin
            beat(16'hC000 + 16'(k), 0);
            expect_grant('0);
            sample("drain");
            adv();
        end

        // Interleaved reads route bursts in issue order, then an orphan beat
        set_req(2, 1'b1, 26'h0000200, 16'h0);
        expect_grant(4'b0100);
        sample("il_rd2");
        adv();
        clear_reqs();
        set_req(1, 1'b1, 26'h0000100, 16'h0);
        expect_grant(4'b0010);
        sample("il_rd1");
        adv();
        clear_reqs();
        for (int k = 0; k < 16; k++) begin
            beat(16'hD000 + 16'(k), (k < 8) ? 2 : 1);
            expect_grant('0);
            sample("il_beat");
            adv();
        end
        beat(16'hDEAD, -1);
        expect_grant('0);
        sample("orphan");
        check("orphan/err_before", 32'(bus.err_orphan), 32'h0);
        adv();
        check("orphan/err_set", 32'(bus.err_orphan), 32'h1);
        adv();
        check("orphan/err_sticky", 32'(bus.err_orphan), 32'h1);

        // Reset in the middle of a burst
        set_req(3, 1'b1, 26'h0000300, 16'h0);
        expect_grant(4'b1000);
        sample("mid_rd3");
        adv();
        clear_reqs();
        for (int k = 0; k < 3; k++) begin
            beat(16'hE000 + 16'(k), 3);
            expect_grant('0);
            sample("mid_beat");
            adv();
        end
        bus.req_write         = '1;
        bus.mem_data_read     = 16'hE003;
        bus.mem_data_read_val = 1'b1;
        reset_n               = 1'b0;
        #1;
        check_all_zero("mid_reset");
        adv();
        clear_reqs();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 26'h400 + 26'(i), 16'h4000 + 16'(i));
        end
        expect_grant(4'b0001);
        sample("post_reset");
        adv();
        clear_reqs();
        beat(16'hE004, -1);
        expect_grant('0);
        sample("post_orphan");
        adv();
        check("post_orphan/err", 32'(bus.err_orphan), 32'h1);

        // Requesters 0 and 2 both held high
        reset_pulse();
        set_req(0, 1'b0, 26'h0000500, 16'h5000);
        set_req(2, 1'b0, 26'h0000502, 16'h5002);
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_PRIO0_EN
            idx = 0;
`else
            idx = (k % 2 == 0) ? 0 : 2;
`endif
            expect_grant(N'(1 << idx));
            sample("pair");
            check("pair/mem_wdata", 32'(bus.mem_data_write), 32'h5000 + 32'(idx));
            adv();
        end
        clear_reqs();
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller command interface among NUM_REQ requesters, e.g. CPU, DMA and video scanout.
- Issues one command per accepted request using work-conserving round-robin arbitration.
- Routes each 8-beat read burst back to the requester that issued it, in issue order, using an internal tag FIFO.
- Sits between the SoC masters and the SDRAM controller's read/write/addr/cmd_ready port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BURST_WORDS, 8, read beats returned per read command; must match the controller burst length.
- TAG_DEPTH, 4, maximum outstanding read bursts (power of 2, ≥2).

Ports:
- clk  in  1  system clock; SDRAM controller runs on the same clock.
- reset_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*26  packed addresses, requester i at [26*i+:26], format {chip, bank[1:0], row[12:0], col[9:0]}.
- req_wdata  in  NUM_REQ*16  packed write data, requester i at [16*i+:16].
- req_ready  out  NUM_REQ  one-hot accept strobe; the request is consumed this cycle.
- rsp_data  out  16  read data, broadcast to all requesters.
- rsp_val  out  NUM_REQ  one-hot read-data-valid per requester.
- mem_read  out  1  read command to the controller.
- mem_write  out  1  write command to the controller.
- mem_addr  out  26  command address.
- mem_data_write  out  16  write data.
- mem_cmd_ready  in  1  controller accepts a command at the next rising edge.
- mem_data_read  in  16  controller read data.
- mem_data_read_val  in  1  controller read data valid.
- err_orphan  out  1  sticky flag: a read beat arrived with no outstanding tag.

Behaviour:
- Reset (async, reset_n=0):
  - rr_ptr = NUM_REQ-1; tag FIFO empty; beat_cnt = 0; err_orphan = 0.
  - All combinational outputs are forced to 0 while in reset.
- Requester protocol:
  - Assert req_read or req_write (never both); hold addr/wdata stable until req_ready pulses.
  - Requester deasserts, or presents its next request, on the cycle after req_ready.
  - req_read and req_write both high from the same requester: treated as a read.
- Eligibility of requester i:
  - (req_read[i] and tag FIFO not full) or req_write[i].
  - A full FIFO masks reads only; writes still proceed.
- Selection:
  - Combinational scan of eligible requesters starting at rr_ptr+1, modulo NUM_REQ; first hit = winner.
- Issue, when mem_cmd_ready=1 and a winner exists:
  - mem_read/mem_write/mem_addr/mem_data_write driven from the winner.
  - req_ready[winner] = 1.
  - rr_ptr <= winner at the clock edge.
  - On a read, push the winner index into the tag FIFO.
- No issue when mem_cmd_ready=0 or no winner:
  - mem_read = mem_write = 0; req_ready = 0; rr_ptr holds.
  - mem_addr/mem_data_write are don't-care, driven from requester 0.
- Latency: zero-cycle pass-through, command to controller in the same cycle it is selected. There are no registered command stages.
- Response routing:
  - rsp_data = mem_data_read.
  - rsp_val[head] = mem_data_read_val when the FIFO is not empty.
  - beat_cnt increments on each valid beat.
  - At beat BURST_WORDS-1: beat_cnt <= 0 and pop the FIFO.
- Simultaneous push and pop: both occur; count unchanged; a full FIFO popping this cycle does NOT unmask reads (eligibility uses the registered count).
- Orphan beat (mem_data_read_val=1, FIFO empty):
  - rsp_val = 0, err_orphan <= 1 (sticky until reset), beat_cnt unchanged.
- Wrap-around: FIFO pointers are log2(TAG_DEPTH) bits wrapping naturally; count is log2(TAG_DEPTH)+1 bits.
- Reset mid-burst: the in-flight burst is discarded; beats after reset deassertion with an empty FIFO raise err_orphan.

Optional Feature:
- Macro: SDRAM_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority; if eligible it always wins.
  - rr_ptr is not updated on a requester-0 grant.
  - Requesters 1..NUM_REQ-1 round-robin among themselves.
- Undefined: pure round-robin across all requesters as above.

Test Plan:
- Single read, req_read[1]=1, addr 26'h0001234, mem_cmd_ready=1 → req_ready=4'b0010 same cycle; mem_read=1, mem_addr=26'h0001234; 8 controller beats 16'hA000..A007 → rsp_val=4'b0010 for exactly 8 cycles, data matches.
- All four assert write continuously, mem_cmd_ready=1 after reset → grant order 0,1,2,3,0,1; mem_data_write tracks winner's req_wdata.
- mem_cmd_ready=0 for 5 cycles with req_write[2]=1 → no req_ready, mem_write=0; first cycle mem_cmd_ready=1 → req_ready[2]=1.
- TAG_DEPTH=4: four reads from req0 accepted, no beats returned; then req0 read + req3 write → only req3 accepted; after the first 8-beat burst completes, req0 read accepted next cycle.
- Interleaved: reads from req2 then req1 → the first 8 beats go to rsp_val[2], the next 8 to rsp_val[1]; orphan beat with empty FIFO → err_orphan=1, stays 1.
- Reset asserted after 3 of 8 beats → all outputs 0 immediately; after release, grant order restarts at 0. With SDRAM_ARB_PRIO0_EN, req0 and req2 held high → req0 wins every cycle.
